// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: front end of the multicycle MIPS datapath.
// Holds the PC, the instruction register and the memory data register. It applies the
// control unit's PC/IR write strobes and slices the IR into decoded fields.
//
// Optional feature: define FETCH_DECODE_PERF_COUNTER_EN to add the InstrCount and
// BranchTakenCount performance counters. Each is CNT_WIDTH bits wide and wraps.
//
// Ports:
//   Clk, reset            clock (rising edge); asynchronous active-high reset
//   PCWrite, PCWriteCond  unconditional / beq-conditional PC write strobes
//   PCSource              next-PC select: 00 ALUResult, 01 ALUOut, 10 JumpTarget, 11 hold
//   IRWrite               IR load strobe
//   Zero                  ALU zero flag
//   ALUResult, ALUOut     combinational and registered ALU results
//   MemData               memory read data
//   PC, Instr, MDR        architectural registers
//   Opcode..JumpTarget    fields decoded from Instr (and from PC for JumpTarget)
//   AddrErr               sticky flag; set when a misaligned value was written to the PC
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  PCSource,
    input  logic        IRWrite,
    input  logic        Zero,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemData,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [31:0] MDR,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [31:0] SignExtImm,
    output logic [31:0] JumpTarget,
    output logic        AddrErr
`ifdef FETCH_DECODE_PERF_COUNTER_EN
    ,
    output logic [CNT_WIDTH-1:0] InstrCount,
    output logic [CNT_WIDTH-1:0] BranchTakenCount
`endif
);

    // A zero-width counter is meaningless, so reject it at elaboration time.
    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    logic        pc_we;
    logic        pc_load;
    logic [31:0] pc_sel;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        addr_err_d;

    // Field decode
    assign Opcode     = Instr[31:26];
    assign Rs         = Instr[25:21];
    assign Rt         = Instr[20:16];
    assign Rd         = Instr[15:11];
    assign Shamt      = Instr[10:6];
    assign Funct      = Instr[5:0];
    assign SignExtImm = {{16{Instr[15]}}, Instr[15:0]};
    assign JumpTarget = {PC[31:28], Instr[25:0], 2'b00};

    // PCWrite dominates PCWriteCond, so Zero only matters for a conditional write.
    assign pc_we = PCWrite | (PCWriteCond & Zero);

    always_comb begin
        pc_sel     = PC;
        pc_load    = 1'b0;
        pc_d       = PC;
        instr_d    = Instr;
        addr_err_d = AddrErr;

        unique case (PCSource)
            2'b00:   pc_sel = ALUResult;
            2'b01:   pc_sel = ALUOut;
            2'b10:   pc_sel = JumpTarget;
            default: pc_sel = PC;
        endcase

        // The reserved select value holds the PC even when the write strobe is asserted.
        pc_load = pc_we & (PCSource != 2'b11);

        if (pc_load) begin
            pc_d = {pc_sel[31:2], 2'b00};
            if (pc_sel[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
        end

        if (IRWrite) begin
            instr_d = MemData;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            PC      <= RESET_PC;
            Instr   <= 32'h0;
            MDR     <= 32'h0;
            AddrErr <= 1'b0;
        end else begin
            PC      <= pc_d;
            Instr   <= instr_d;
            MDR     <= MemData;
            AddrErr <= addr_err_d;
        end
    end

`ifdef FETCH_DECODE_PERF_COUNTER_EN
    logic branch_taken;

    // Count only branches taken through the conditional path, not unconditional writes.
    assign branch_taken = PCWriteCond & Zero & ~PCWrite;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            InstrCount       <= '0;
            BranchTakenCount <= '0;
        end else begin
            if (IRWrite) begin
                InstrCount <= InstrCount + 1'b1;
            end
            if (branch_taken) begin
                BranchTakenCount <= BranchTakenCount + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed scenarios followed by randomized
// stimulus. Everything is compared against a behavioural model of the architectural state.
module tb_fetch_decode_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned CNT_WIDTH = 4;

    logic        Clk;
    logic        reset;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  PCSource;
    logic        IRWrite;
    logic        Zero;
    logic [31:0] ALUResult;
    logic [31:0] ALUOut;
    logic [31:0] MemData;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] MDR;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [31:0] SignExtImm;
    logic [31:0] JumpTarget;
    logic        AddrErr;
`ifdef FETCH_DECODE_PERF_COUNTER_EN
    logic [CNT_WIDTH-1:0] InstrCount;
    logic [CNT_WIDTH-1:0] BranchTakenCount;
`endif

    fetch_decode_unit #(
        .RESET_PC  (RESET_PC),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .IRWrite     (IRWrite),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .MemData     (MemData),
        .PC          (PC),
        .Instr       (Instr),
        .MDR         (MDR),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
        .Shamt       (Shamt),
        .SignExtImm  (SignExtImm),
        .JumpTarget  (JumpTarget),
        .AddrErr     (AddrErr)
`ifdef FETCH_DECODE_PERF_COUNTER_EN
        ,
        .InstrCount       (InstrCount),
        .BranchTakenCount (BranchTakenCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    longint unsigned m_pc, m_ir, m_mdr, m_ic, m_bc;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_ir  = 0;
        m_mdr = 0;
        m_err = 0;
        m_ic  = 0;
        m_bc  = 0;
    endtask

    task automatic check_all(input string tag);
        longint unsigned imm;
        imm = m_ir % 65536;
        if (imm >= 32768) imm = imm + 64'hFFFF_0000;
        check_eq({tag, ".pc"},     PC,      32'(m_pc));
        check_eq({tag, ".instr"},  Instr,   32'(m_ir));
        check_eq({tag, ".mdr"},    MDR,     32'(m_mdr));
        check_eq({tag, ".addrerr"}, 32'(AddrErr), 32'(m_err));
        check_eq({tag, ".opcode"}, 32'(Opcode), 32'(m_ir / 2**26));
        check_eq({tag, ".rs"},     32'(Rs),     32'((m_ir / 2**21) % 32));
        check_eq({tag, ".rt"},     32'(Rt),     32'((m_ir / 2**16) % 32));
        check_eq({tag, ".rd"},     32'(Rd),     32'((m_ir / 2**11) % 32));
        check_eq({tag, ".shamt"},  32'(Shamt),  32'((m_ir / 2**6) % 32));
        check_eq({tag, ".funct"},  32'(Funct),  32'(m_ir % 64));
        check_eq({tag, ".simm"},   SignExtImm,  32'(imm));
        check_eq({tag, ".jt"},     JumpTarget,
                 32'((m_pc / 2**28) * 2**28 + (m_ir % 2**26) * 4));
`ifdef FETCH_DECODE_PERF_COUNTER_EN
        check_eq({tag, ".icnt"},   32'(InstrCount),       32'(m_ic));
        check_eq({tag, ".bcnt"},   32'(BranchTakenCount), 32'(m_bc));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input string tag, input logic pcw, input logic pcwc,
                        input logic [1:0] src, input logic irw, input logic zero,
                        input logic [31:0] alur, input logic [31:0] aluo,
                        input logic [31:0] mem);
        longint unsigned jt, sel, n_pc;
        bit n_err;
        PCWrite     = pcw;
        PCWriteCond = pcwc;
        PCSource    = src;
        IRWrite     = irw;
        Zero        = zero;
        ALUResult   = alur;
        ALUOut      = aluo;
        MemData     = mem;
        jt    = (m_pc / 2**28) * 2**28 + (m_ir % 2**26) * 4;
        n_pc  = m_pc;
        n_err = m_err;
        if ((pcw || (pcwc && zero)) && src != 2'd3) begin
            sel   = (src == 2'd0) ? alur : (src == 2'd1) ? aluo : jt;
            if (sel % 4 != 0) n_err = 1;
            n_pc  = sel - (sel % 4);
        end
        @(posedge Clk);
        #1;
        m_pc  = n_pc;
        m_err = n_err;
        if (irw) m_ir = mem;
        m_mdr = mem;
        if (irw) m_ic = (m_ic + 1) % (2**CNT_WIDTH);
        if (pcwc && zero && !pcw) m_bc = (m_bc + 1) % (2**CNT_WIDTH);
        check_all(tag);
    endtask

    // Pulse reset between clock edges and check its effect before the next edge.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        PCWrite = 0; PCWriteCond = 0; PCSource = 0; IRWrite = 0; Zero = 0;
        ALUResult = 0; ALUOut = 0; MemData = 0;
        model_reset();
        #2;
        check_all("reset0");
        #1;
        reset = 1'b0;

        // Fetch
        step("fetch", 1, 0, 2'd0, 1, 0, 32'h4, 32'h0, 32'h8C22_0004);
        check_eq("fetch.opcode_lit", 32'(Opcode), 32'h23);
        check_eq("fetch.simm_lit", SignExtImm, 32'h4);

        // Branch not taken, then taken
        step("setpc10", 1, 0, 2'd0, 0, 0, 32'h10, 32'h0, 32'h0);
        step("br_nt", 0, 1, 2'd1, 0, 0, 32'h0, 32'h40, 32'h0);
        check_eq("br_nt.pc_lit", PC, 32'h10);
        step("br_t", 0, 1, 2'd1, 0, 1, 32'h0, 32'h40, 32'h0);
        check_eq("br_t.pc_lit", PC, 32'h40);

        // Reserved select holds the PC
        step("rsvd", 1, 0, 2'd3, 0, 0, 32'h100, 32'h200, 32'h0);

        // Jump
        step("setjmp", 1, 0, 2'd0, 1, 0, 32'h9000_0008, 32'h0, 32'h0800_0010);
        step("jump", 1, 0, 2'd2, 0, 0, 32'h0, 32'h0, 32'h0);
        check_eq("jump.pc_lit", PC, 32'h9000_0040);

        // Misaligned write sets the sticky flag
        async_reset("rst_mid");
        step("misal", 1, 0, 2'd0, 0, 0, 32'h6, 32'h0, 32'h0);
        check_eq("misal.pc_lit", PC, 32'h4);
        check_eq("misal.err_lit", 32'(AddrErr), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step("sticky", 1, 0, 2'd0, 0, 0, 32'(8 + 4 * i), 32'h0, 32'h0);
        end
        check_eq("sticky.err_lit", 32'(AddrErr), 32'h1);
        async_reset("rst_clr");

        // Counter wrap and taken-branch filtering
        for (int i = 0; i < 17; i++) begin
            step("icnt", 0, 0, 2'd0, 1, 0, 32'h0, 32'h0, $urandom);
        end
        for (int i = 0; i < 3; i++) begin
            step("bcnt", 0, 1, 2'd1, 0, 1, 32'h0, 32'h80, 32'h0);
        end
        step("bcnt_pcw", 1, 1, 2'd1, 0, 1, 32'h0, 32'h80, 32'h0);
`ifdef FETCH_DECODE_PERF_COUNTER_EN
        check_eq("icnt.wrap_lit", 32'(InstrCount), 32'h1);
        check_eq("bcnt.lit", 32'(BranchTakenCount), 32'h3);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] alur, aluo;
            alur = $urandom;
            aluo = $urandom;
            if ($urandom_range(0, 7) != 0) alur[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) aluo[1:0] = 2'b00;
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
            end
            step("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), alur, aluo, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
